fetch_unit: RTL and testbench

//  Instruction-fetch requester for the pipelined core; the counterpart of the instruction memory.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_skid_reg.sv | 37 +++
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, state encoding and the out-of-range test used by the fetch unit.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h00000033;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } fetch_state_t;

  // True when the word index of a byte PC lies outside the instruction memory.
  function automatic logic is_oob(input logic [31:0] pc, input logic [31:0] words);
    return {2'b00, pc[31:2]} >= words;
  endfunction

endpackage

// File: rtl/fetch_skid_reg.sv
// One-entry hold register that parks a fetch response while decode is stalled.
module fetch_skid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_fault,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_fault
);

  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_fault;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_instr <= NOP_INSTR;
      r_pc    <= 32'h0;
      r_fault <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc    <= i_pc;
      r_fault <= i_fault;
    end
  end

  assign o_instr = r_instr;
  assign o_pc    = r_pc;
  assign o_fault = r_fault;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch requester: owns the PC, tracks the one-cycle memory response,
// and feeds decode through a valid/ready handshake with a single-entry skid.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 32,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] if_id_instruction,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  logic [31:0]  r_pc;
  logic         r_rsp_valid;
  logic [31:0]  r_rsp_pc;
  fetch_state_t r_state;

  logic         w_rsp_oob;
  logic         w_rsp_fault;
  logic [31:0]  w_rsp_instr;
  logic         w_capture;
  logic         w_advance;
  logic [31:0]  w_hold_instr;
  logic [31:0]  w_hold_pc;
  logic         w_hold_fault;

  assign pc_out = {2'b00, r_pc[31:2]};

  // Out-of-range responses are replaced by a NOP before they reach decode or the hold.
  assign w_rsp_oob   = is_oob(r_rsp_pc, 32'(IMEM_WORDS));
  assign w_rsp_fault = r_rsp_valid & w_rsp_oob;
  assign w_rsp_instr = (r_rsp_valid && !w_rsp_oob) ? if_id_instruction : NOP_INSTR;

  assign w_capture = (r_state == RUN) && r_rsp_valid && !id_ready && !redirect_valid;
  assign w_advance = (r_state == RUN) ? (!r_rsp_valid || id_ready) : id_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_rsp_valid <= 1'b0;
      r_rsp_pc    <= 32'h0;
      r_state     <= RUN;
    end else begin
      r_rsp_pc    <= r_pc;
      r_rsp_valid <= !redirect_valid;
      if (redirect_valid) begin
        r_pc    <= redirect_pc & ~32'd3;
        r_state <= RUN;
      end else begin
        if (w_advance) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_capture) begin
          r_state <= HELD;
        end else if (r_state == HELD && id_ready) begin
          r_state <= RUN;
        end
      end
    end
  end

  fetch_skid_reg u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_capture),
    .i_clear (redirect_valid),
    .i_instr (w_rsp_instr),
    .i_pc    (r_rsp_pc),
    .i_fault (w_rsp_fault),
    .o_instr (w_hold_instr),
    .o_pc    (w_hold_pc),
    .o_fault (w_hold_fault)
  );

  // A redirect squashes whatever is on offer this cycle, held or not.
  always_comb begin
    if (r_state == HELD) begin
      id_valid = !redirect_valid;
      id_instr = w_hold_instr;
      id_pc    = w_hold_pc;
      id_fault = w_hold_fault;
    end else begin
      id_valid = r_rsp_valid && !redirect_valid;
      id_instr = w_rsp_instr;
      id_pc    = r_rsp_pc;
      id_fault = w_rsp_fault;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 1-cycle registered instruction memory model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h00000033;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_out;
  logic [31:0] if_id_instruction;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic        rst;
    logic        rdv;
    logic [31:0] rdpc;
    logic        rdy;
    logic        ev;    // expect a valid offer with the given pc
    logic        erst;  // expect the post-reset idle outputs
    logic [31:0] epc;
    logic [31:0] eout;
  } vec_t;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk               (clk),
    .rst               (rst),
    .pc_out            (pc_out),
    .if_id_instruction (if_id_instruction),
    .id_valid          (id_valid),
    .id_ready          (id_ready),
    .id_instr          (id_instr),
    .id_pc             (id_pc),
    .id_fault          (id_fault),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] k);
    return 32'h00100013 + (k << 20);
  endfunction

  always @(posedge clk) if_id_instruction <= mem_word(pc_out);

  function automatic logic exp_fault(input logic [31:0] pc);
    return pc[31:2] >= 30'd32;
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return exp_fault(pc) ? NOP : mem_word({2'b00, pc[31:2]});
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input vec_t v);
    rst            = v.rst;
    redirect_valid = v.rdv;
    redirect_pc    = v.rdpc;
    id_ready       = v.rdy;
    #1;
  endtask

  function automatic vec_t V(input logic r, input logic rdv, input logic [31:0] rdpc, input logic rdy,
                             input logic ev, input logic erst, input logic [31:0] epc, input logic [31:0] eout);
    V = '{rst: r, rdv: rdv, rdpc: rdpc, rdy: rdy, ev: ev, erst: erst, epc: epc, eout: eout};
  endfunction

  task automatic test_reset();
    vec_t v [0:2];
    logic [97:0] got, want, mask;
    rst = 1'b1;
    step();
    step();
    v[0] = V(0, 0, 0, 1, 0, 1, 32'h0, 32'd0);
    v[1] = V(0, 0, 0, 1, 1, 0, 32'h0, 32'd1);
    v[2] = V(0, 0, 0, 1, 1, 0, 32'h4, 32'd2);
    for (int i = 0; i < 3; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = v[i].erst ? {1'b0, 32'h0, NOP, 1'b0, v[i].eout}
                       : {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = (v[i].ev || v[i].erst) ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL reset[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h (mask %h)",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want, mask);
      end
      step();
    end
  endtask

  task automatic test_stall();
    vec_t v [0:5];
    logic [97:0] got, want, mask;
    v[0] = V(0, 0, 0, 0, 1, 0, 32'h8,  32'd3);
    v[1] = V(0, 0, 0, 0, 1, 0, 32'h8,  32'd3);
    v[2] = V(0, 0, 0, 0, 1, 0, 32'h8,  32'd3);
    v[3] = V(0, 0, 0, 1, 1, 0, 32'h8,  32'd3);
    v[4] = V(0, 0, 0, 1, 1, 0, 32'hC,  32'd4);
    v[5] = V(0, 0, 0, 1, 1, 0, 32'h10, 32'd5);
    for (int i = 0; i < 6; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = v[i].ev ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL stall[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want);
      end
      step();
    end
  endtask

  task automatic test_redirect();
    vec_t v [0:3];
    logic [97:0] got, want, mask;
    v[0] = V(0, 1, 32'h12, 1, 0, 0, 32'h0,  32'd6);
    v[1] = V(0, 0, 0,      1, 0, 0, 32'h0,  32'd4);
    v[2] = V(0, 0, 0,      1, 1, 0, 32'h10, 32'd5);
    v[3] = V(0, 0, 0,      1, 1, 0, 32'h14, 32'd6);
    for (int i = 0; i < 4; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = v[i].ev ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL redirect[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want);
      end
      step();
    end
  endtask

  task automatic test_redirect_held();
    vec_t v [0:8];
    logic [97:0] got, want, mask;
    v[0] = V(0, 1, 32'h0,  1, 0, 0, 32'h0,  32'd7);
    v[1] = V(0, 0, 0,      1, 0, 0, 32'h0,  32'd0);
    v[2] = V(0, 0, 0,      1, 1, 0, 32'h0,  32'd1);
    v[3] = V(0, 0, 0,      1, 1, 0, 32'h4,  32'd2);
    v[4] = V(0, 0, 0,      0, 1, 0, 32'h8,  32'd3);
    v[5] = V(0, 1, 32'h40, 0, 0, 0, 32'h0,  32'd3);
    v[6] = V(0, 0, 0,      1, 0, 0, 32'h0,  32'd16);
    v[7] = V(0, 0, 0,      1, 1, 0, 32'h40, 32'd17);
    v[8] = V(0, 0, 0,      1, 1, 0, 32'h44, 32'd18);
    for (int i = 0; i < 9; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = v[i].ev ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL redirect_held[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want);
      end
      step();
    end
  endtask

  task automatic test_fault();
    vec_t v [0:6];
    logic [97:0] got, want, mask;
    v[0] = V(0, 1, 32'h78, 1, 0, 0, 32'h0,  32'd19);
    v[1] = V(0, 0, 0,      1, 0, 0, 32'h0,  32'd30);
    v[2] = V(0, 0, 0,      1, 1, 0, 32'h78, 32'd31);
    v[3] = V(0, 0, 0,      1, 1, 0, 32'h7C, 32'd32);
    v[4] = V(0, 0, 0,      0, 1, 0, 32'h80, 32'd33);
    v[5] = V(0, 0, 0,      1, 1, 0, 32'h80, 32'd33);
    v[6] = V(0, 0, 0,      1, 1, 0, 32'h84, 32'd34);
    for (int i = 0; i < 7; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = v[i].ev ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL fault[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stall();
    vec_t v [0:4];
    logic [97:0] got, want, mask;
    v[0] = V(0, 0, 0, 0, 1, 0, 32'h88, 32'd35);
    v[1] = V(1, 0, 0, 0, 1, 0, 32'h88, 32'd35);
    v[2] = V(0, 0, 0, 1, 0, 1, 32'h0,  32'd0);
    v[3] = V(0, 0, 0, 1, 1, 0, 32'h0,  32'd1);
    v[4] = V(0, 0, 0, 1, 1, 0, 32'h4,  32'd2);
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = v[i].erst ? {1'b0, 32'h0, NOP, 1'b0, v[i].eout}
                       : {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = (v[i].ev || v[i].erst) ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL reset_mid_stall[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want);
      end
      step();
    end
  endtask

  task automatic test_wrap();
    vec_t v [0:4];
    logic [97:0] got, want, mask;
    v[0] = V(0, 1, 32'hFFFFFFFF, 1, 0, 0, 32'h0,        32'd3);
    v[1] = V(0, 0, 0,            1, 0, 0, 32'h0,        32'h3FFFFFFF);
    v[2] = V(0, 0, 0,            1, 1, 0, 32'hFFFFFFFC, 32'd0);
    v[3] = V(0, 0, 0,            1, 1, 0, 32'h0,        32'd1);
    v[4] = V(0, 0, 0,            1, 1, 0, 32'h4,        32'd2);
    for (int i = 0; i < 5; i++) begin
      drive(v[i]);
      got  = {id_valid, id_pc, id_instr, id_fault, pc_out};
      want = {v[i].ev, v[i].epc, exp_instr(v[i].epc), exp_fault(v[i].epc), v[i].eout};
      mask = v[i].ev ? {98{1'b1}} : {1'b1, 65'h0, 32'hFFFFFFFF};
      vectors++;
      if ((got & mask) !== (want & mask)) begin
        miscompares++;
        $display("FAIL wrap[%0d] got v=%b pc=%h ins=%h f=%b out=%h want %h",
                 i, id_valid, id_pc, id_instr, id_fault, pc_out, want);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_held();
    test_fault();
    test_reset_mid_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
